// File: rtl/immediate_stage_pkg.sv
// Shared types and helpers for the immediate extraction stage.
// Provides the immediate format selector, the legal datapath widths and the
// extraction function. The function always builds a 64-bit result; callers
// narrow it to their XLEN with a size cast. For XLEN=32 the low word is the
// correctly sign- or zero-extended value.
package immediate_stage_pkg;

    localparam int XLEN_RV32     = 32;
    localparam int XLEN_RV64     = 64;
    localparam int IMM_MAX_WIDTH = 64;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4,
        IMM_Z = 3'd5
    } immediate_e;

    function automatic logic legal_xlen(input int xlen);
        return (xlen == XLEN_RV32) || (xlen == XLEN_RV64);
    endfunction

    // Selector values 6 and 7 are not defined formats; they decode as I.
    function automatic logic [IMM_MAX_WIDTH-1:0] imm_extract(
        input logic [31:0] instr,
        input immediate_e  sel
    );
        logic [IMM_MAX_WIDTH-1:0] imm;
        logic                     s;
        s = instr[31];
        case (sel)
            IMM_S:   imm = {{52{s}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{52{s}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            // LUI semantics: the 32-bit upper immediate is then sign-extended.
            IMM_U:   imm = {{32{s}}, instr[31:12], 12'h000};
            IMM_J:   imm = {{44{s}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            // CSR uimm: rs1 field, never sign-extended.
            IMM_Z:   imm = {59'd0, instr[19:15]};
            default: imm = {{52{s}}, instr[31:20]};
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/immediate_stage_skid_buffer.sv
// Generic two-register skid buffer (OUT + SKID) with valid/ready handshakes.
// Latency: 1 cycle from input fire to valid_o when OUT is empty or draining.
// Backpressure: ready_o = !skid_valid, driven from a register; flush empties both.
// Ports: clk_i, rst_ni (sync, active low), flush_i, valid_i/ready_o/data_i
//        upstream, valid_o/ready_i/data_o downstream.
module skid_buffer #(
    parameter int WIDTH = 64
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o
);

    logic             out_valid;
    logic             skid_valid;
    logic [WIDTH-1:0] out_data;
    logic [WIDTH-1:0] skid_data;
    logic             in_fire;
    logic             out_fire;

    assign ready_o  = !skid_valid;
    assign valid_o  = out_valid;
    assign data_o   = out_data;
    assign in_fire  = valid_i && ready_o;
    assign out_fire = out_valid && ready_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            out_data   <= '0;
            skid_data  <= '0;
        end else if (flush_i) begin
            // Anything accepted this cycle is dropped along with held entries.
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!out_valid || out_fire) begin
            if (skid_valid) begin
                // SKID is older than anything arriving now, so it goes first.
                out_data   <= skid_data;
                out_valid  <= 1'b1;
                skid_valid <= in_fire;
                if (in_fire) begin
                    skid_data <= data_i;
                end
            end else if (in_fire) begin
                out_data  <= data_i;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (in_fire) begin
            // OUT stalled: park the new entry; ready_o drops next cycle.
            skid_data  <= data_i;
            skid_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/immediate_stage.sv
// Registered immediate extraction between decode and execute, tag passthrough.
// Latency: 1 cycle; full throughput while ready_i stays high.
// Backpressure: 2-entry skid buffer, ready_o is a register output.
// Ports: clk_i, rst_ni, flush_i, valid_i/ready_o/instruction_i/selector_i/tag_i
//        upstream, valid_o/ready_i/immediate_o/tag_o downstream.
module immediate_stage
    import immediate_stage_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int TAG_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [31:0]          instruction_i,
    input  immediate_e           selector_i,
    input  logic [TAG_WIDTH-1:0] tag_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [XLEN-1:0]      immediate_o,
    output logic [TAG_WIDTH-1:0] tag_o
);

    localparam int ENTRY_WIDTH = XLEN + TAG_WIDTH;

    generate
        if (!legal_xlen(XLEN)) begin : g_bad_xlen
            $error("immediate_stage: XLEN must be 32 or 64");
        end
        if (TAG_WIDTH < 1) begin : g_bad_tag
            $error("immediate_stage: TAG_WIDTH must be at least 1");
        end
    endgenerate

    logic [XLEN-1:0]        imm;
    logic [ENTRY_WIDTH-1:0] entry_in;
    logic [ENTRY_WIDTH-1:0] entry_out;

    // The 64-bit result narrows cleanly: its low word is already extended.
    assign imm      = XLEN'(imm_extract(instruction_i, selector_i));
    assign entry_in = {tag_i, imm};

    skid_buffer #(
        .WIDTH (ENTRY_WIDTH)
    ) u_skid (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (entry_in),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (entry_out)
    );

    assign immediate_o = entry_out[XLEN-1:0];
    assign tag_o       = entry_out[ENTRY_WIDTH-1:XLEN];

endmodule

// File: tb/tb_immediate_stage.sv
module tb_immediate_stage;
    import immediate_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        flush;
    logic        valid_in;
    logic [31:0] instr;
    immediate_e  sel;
    logic [31:0] tag_in;
    logic        ready_down;

    logic        ready64, valid64;
    logic [63:0] imm64;
    logic [31:0] tag64;
    logic        ready32, valid32;
    logic [31:0] imm32;
    logic [31:0] tag32;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    immediate_stage #(.XLEN(64), .TAG_WIDTH(32)) dut64 (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush), .valid_i(valid_in),
        .ready_o(ready64), .instruction_i(instr), .selector_i(sel), .tag_i(tag_in),
        .valid_o(valid64), .ready_i(ready_down), .immediate_o(imm64), .tag_o(tag64)
    );

    immediate_stage #(.XLEN(32), .TAG_WIDTH(32)) dut32 (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush), .valid_i(valid_in),
        .ready_o(ready32), .instruction_i(instr), .selector_i(sel), .tag_i(tag_in),
        .valid_o(valid32), .ready_i(ready_down), .immediate_o(imm32), .tag_o(tag32)
    );

    typedef struct {
        string       name;
        logic [31:0] instr;
        immediate_e  sel;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] i, input immediate_e s, input logic [31:0] t);
        valid_in = v;
        instr    = i;
        sel      = s;
        tag_in   = t;
    endtask

    initial begin
        vecs.push_back('{"i_neg",   32'hFFF00093, IMM_I, 64'hFFFF_FFFF_FFFF_FFFF});
        vecs.push_back('{"u_neg",   32'h800000B7, IMM_U, 64'hFFFF_FFFF_8000_0000});
        vecs.push_back('{"u_pos",   32'h123450B7, IMM_U, 64'h0000_0000_1234_5000});
        vecs.push_back('{"b_neg",   32'hFE000EE3, IMM_B, 64'hFFFF_FFFF_FFFF_FFFC});
        vecs.push_back('{"j_pos",   32'h0080006F, IMM_J, 64'h0000_0000_0000_0008});
        vecs.push_back('{"z_max",   32'h800F8073, IMM_Z, 64'h0000_0000_0000_001F});
        vecs.push_back('{"i_pos",   32'h7FF00093, IMM_I, 64'h0000_0000_0000_07FF});
        vecs.push_back('{"s_neg",   32'hFE112E23, IMM_S, 64'hFFFF_FFFF_FFFF_FFFC});
        vecs.push_back('{"s_pos",   32'h00A12423, IMM_S, 64'h0000_0000_0000_0008});
        vecs.push_back('{"b_pos",   32'h00000463, IMM_B, 64'h0000_0000_0000_0008});
        vecs.push_back('{"j_neg",   32'hFFDFF06F, IMM_J, 64'hFFFF_FFFF_FFFF_FFFC});
        vecs.push_back('{"unk_sel", 32'h7FF00093, immediate_e'(3'd7), 64'h0000_0000_0000_07FF});

        rst_ni = 1'b0; flush = 1'b0; ready_down = 1'b1;
        drive(1'b0, 32'h0, IMM_I, 32'h0);
        repeat (2) @(negedge clk);
        check("rst_valid64", {63'd0, valid64}, 64'd0);
        check("rst_ready64", {63'd0, ready64}, 64'd1);
        check("rst_imm64", imm64, 64'd0);
        check("rst_tag64", {32'd0, tag64}, 64'd0);
        check("rst_valid32", {63'd0, valid32}, 64'd0);
        check("rst_ready32", {63'd0, ready32}, 64'd1);
        rst_ni = 1'b1;

        // Table: one vector per cycle, each checked one cycle after it is driven.
        for (int k = 0; k <= vecs.size(); k++) begin
            @(negedge clk);
            if (k > 0) begin
                check({"vld_", vecs[k-1].name}, {63'd0, valid64}, 64'd1);
                check({"imm64_", vecs[k-1].name}, imm64, vecs[k-1].exp);
                check({"tag64_", vecs[k-1].name}, {32'd0, tag64}, 64'(k - 1));
                check({"imm32_", vecs[k-1].name}, {32'd0, imm32}, {32'd0, vecs[k-1].exp[31:0]});
                check({"tag32_", vecs[k-1].name}, {32'd0, tag32}, 64'(k - 1));
            end
            if (k < vecs.size()) drive(1'b1, vecs[k].instr, vecs[k].sel, 32'(k));
            else drive(1'b0, 32'h0, IMM_I, 32'h0);
        end

        // Backpressure: tags 1,2 fill OUT and SKID; tag 3 must wait.
        @(negedge clk);
        check("bp_idle", {63'd0, valid64}, 64'd0);
        ready_down = 1'b0;
        drive(1'b1, 32'hFFF00093, IMM_I, 32'd1);
        @(negedge clk);
        check("bp_rdy_after1", {63'd0, ready64}, 64'd1);
        drive(1'b1, 32'h123450B7, IMM_U, 32'd2);
        @(negedge clk);
        check("bp_rdy_after2", {63'd0, ready64}, 64'd0);
        check("bp_hold_tag", {32'd0, tag64}, 64'd1);
        drive(1'b1, 32'h0080006F, IMM_J, 32'd3);
        @(negedge clk);
        check("bp_third_blocked", {63'd0, ready64}, 64'd0);
        check("bp_hold_vld", {63'd0, valid64}, 64'd1);
        check("bp_hold_tag2", {32'd0, tag64}, 64'd1);
        check("bp_hold_imm", imm64, 64'hFFFF_FFFF_FFFF_FFFF);
        ready_down = 1'b1;
        @(negedge clk);
        check("bp_out2_vld", {63'd0, valid64}, 64'd1);
        check("bp_out2_tag", {32'd0, tag64}, 64'd2);
        check("bp_out2_imm", imm64, 64'h0000_0000_1234_5000);
        check("bp_rdy_back", {63'd0, ready64}, 64'd1);
        @(negedge clk);
        check("bp_out3_vld", {63'd0, valid64}, 64'd1);
        check("bp_out3_tag", {32'd0, tag64}, 64'd3);
        check("bp_out3_imm", imm64, 64'h0000_0000_0000_0008);
        drive(1'b0, 32'h0, IMM_I, 32'h0);
        @(negedge clk);
        check("bp_drained", {63'd0, valid64}, 64'd0);

        // Throughput: 16 back-to-back entries, one fire per cycle.
        for (int k = 0; k <= 16; k++) begin
            @(negedge clk);
            check("tp_ready", {63'd0, ready64}, 64'd1);
            if (k > 0) begin
                check("tp_vld", {63'd0, valid64}, 64'd1);
                check("tp_tag", {32'd0, tag64}, 64'(100 + k - 1));
                check("tp_imm", imm64, 64'(k - 1));
            end
            if (k < 16) drive(1'b1, {12'(k), 20'h00093}, IMM_I, 32'(100 + k));
            else drive(1'b0, 32'h0, IMM_I, 32'h0);
        end

        // Flush with OUT and SKID full and a third entry offered.
        @(negedge clk);
        ready_down = 1'b0;
        drive(1'b1, 32'h0, IMM_I, 32'h51);
        @(negedge clk);
        drive(1'b1, 32'h0, IMM_I, 32'h52);
        @(negedge clk);
        check("fl_full", {63'd0, ready64}, 64'd0);
        drive(1'b1, 32'h0, IMM_I, 32'h53);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        ready_down = 1'b1;
        drive(1'b0, 32'h0, IMM_I, 32'h0);
        check("fl_vld", {63'd0, valid64}, 64'd0);
        check("fl_rdy", {63'd0, ready64}, 64'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("fl_no_ghost", {63'd0, valid64}, 64'd0);
        end

        // Flush beats an input fire while ready_o is high.
        ready_down = 1'b0;
        drive(1'b1, 32'h0, IMM_I, 32'h61);
        @(negedge clk);
        check("fl2_rdy", {63'd0, ready64}, 64'd1);
        drive(1'b1, 32'h0, IMM_I, 32'h62);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        ready_down = 1'b1;
        drive(1'b0, 32'h0, IMM_I, 32'h0);
        check("fl2_vld", {63'd0, valid64}, 64'd0);
        @(negedge clk);
        check("fl2_no_ghost", {63'd0, valid64}, 64'd0);

        // Reset with both registers full, then a fresh entry.
        ready_down = 1'b0;
        drive(1'b1, 32'hFFF00093, IMM_I, 32'h71);
        @(negedge clk);
        drive(1'b1, 32'hFFF00093, IMM_I, 32'h72);
        @(negedge clk);
        drive(1'b0, 32'h0, IMM_I, 32'h0);
        rst_ni = 1'b0;
        @(negedge clk);
        check("rs_vld", {63'd0, valid64}, 64'd0);
        check("rs_rdy", {63'd0, ready64}, 64'd1);
        check("rs_imm", imm64, 64'd0);
        check("rs_tag", {32'd0, tag64}, 64'd0);
        check("rs_imm32", {32'd0, imm32}, 64'd0);
        rst_ni = 1'b1;
        ready_down = 1'b1;
        drive(1'b1, 32'h800F8073, IMM_Z, 32'h77);
        @(negedge clk);
        drive(1'b0, 32'h0, IMM_I, 32'h0);
        check("rs_first_vld", {63'd0, valid64}, 64'd1);
        check("rs_first_tag", {32'd0, tag64}, 64'h77);
        check("rs_first_imm", imm64, 64'h1F);
        @(negedge clk);
        check("rs_end_idle", {63'd0, valid64}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/immediate_stage.md
Name: immediate_stage

Overview:
Registered, XLEN-parametrised immediate extraction stage between instruction fetch/decode and execute. Supports RV32/RV64 sign extension and a CSR zero-extended immediate (IMM_Z). Uses a valid/ready handshake with a 2-entry skid buffer, so `ready_o` is driven from a register and the stage runs at full throughput under backpressure. A caller-defined tag (PC, rd, etc.) travels alongside each immediate.

Parameters:
- XLEN, 32, datapath width in bits; legal values are 32 or 64.
- TAG_WIDTH, 32, width of the sideband tag that passes through unmodified; must be at least 1.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  synchronous active-low reset
- flush_i  input  1  synchronously discard all held entries
- valid_i  input  1  upstream entry valid
- ready_o  output  1  stage can accept an entry this cycle
- instruction_i  input  32  raw instruction word
- selector_i  input  immediate_e  immediate format (IMM_I/S/B/U/J/Z)
- tag_i  input  TAG_WIDTH  sideband carried with the entry
- valid_o  output  1  downstream entry valid
- ready_i  input  1  downstream accepts the entry
- immediate_o  output  XLEN  extracted immediate
- tag_o  output  TAG_WIDTH  tag of the entry on the output

Behaviour:
- Handshakes: input fires when `valid_i && ready_o`; output fires when `valid_o && ready_i`.
- Immediate extraction is combinational on the inputs and is registered on accept.
- Latency is 1 cycle: an entry accepted in cycle N is visible on `valid_o` in cycle N+1 if the output register was empty or firing in cycle N.
- Extension rules:
  - I, S, B, J: sign-extended from `instruction_i[31]` to XLEN.
  - U: `{instruction_i[31:12], 12'h000}`, then sign-extended from bit 31 to XLEN (RV64 LUI semantics).
  - Z: `instruction_i[19:15]`, zero-extended to XLEN.
  - Unknown selector values decode as I.
- Storage is an output register (OUT) plus a skid register (SKID), each with its own valid bit.
- `ready_o` equals `!skid_valid` and is a registered signal only.
- Per-cycle update (flush and reset aside):
  - OUT empty, or OUT firing: OUT loads from SKID if SKID is valid; otherwise OUT loads the input if the input fires; otherwise OUT becomes empty. When SKID drains into OUT and the input also fires, the input goes into SKID.
  - OUT full and stalled: if the input fires, it goes into SKID. The input can only fire here when SKID is empty.
- Ordering is strictly FIFO. No entry is dropped or duplicated.
- `flush_i` clears both valid bits next cycle and has priority over an input fire in the same cycle; the accepted entry is discarded. `ready_o` is 1 the cycle after a flush. The output handshake in the flush cycle still completes normally for downstream.
- Reset (`rst_ni == 0` at a clock edge):
  - `valid_o` = 0, `ready_o` = 1, both valid bits = 0, `immediate_o` = 0, `tag_o` = 0.
  - Any entry in flight is lost; no output fire occurs during reset.
- While `valid_o` is 0, `immediate_o` and `tag_o` hold their last values. The bench must not check them then.
- Outputs must not change while `valid_o && !ready_i`.
- Elaboration error if XLEN is not 32 or 64.

Decomposition:
- Shared package/header `immediate.svh`:
  - Extend `immediate_e` with IMM_Z.
  - Add an `imm_extract` function parametrised on XLEN.
  - Legal-XLEN constants.
- Sub-module `skid_buffer` (parameter WIDTH, same handshake and flush semantics). It is generic and reusable by later pipeline stages. `immediate_stage` instantiates it with WIDTH = XLEN + TAG_WIDTH.

Test Plan:
- XLEN=64, `ready_i`=1:
  - 0xFFF00093 / IMM_I → 0xFFFF_FFFF_FFFF_FFFF one cycle later.
  - 0x800000B7 / IMM_U → 0xFFFF_FFFF_8000_0000.
  - 0x123450B7 / IMM_U → 0x0000_0000_1234_5000.
- XLEN=32:
  - 0xFE000EE3 / IMM_B → 0xFFFF_FFFC.
  - 0x0080006F / IMM_J → 0x0000_0008.
  - Instruction with [19:15]=5'h1F and [31]=1 / IMM_Z → 0x0000_001F.
- Backpressure: hold `ready_i`=0 and push tags 1, 2 → `ready_o` falls after the second accept and a third `valid_i` is not accepted. Raise `ready_i` → tags 1, 2, 3 emerge on consecutive cycles with matching immediates.
- Throughput: stream 16 entries with `ready_i`=1 → 16 output fires on 16 consecutive cycles, `ready_o` stays 1 throughout.
- Flush: with OUT and SKID full and `valid_i`=1 in the same cycle → next cycle `valid_o`=0 and `ready_o`=1; none of the three entries ever appears.
- Reset with both registers full → `valid_o`=0, `ready_o`=1, outputs 0. The first post-reset entry appears after exactly 1 cycle.
